game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 23 ++
 rtl/game_ctrl.sv | 157 +++++++++++++++
 tb/tb_game_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Handshake bundle between the game controller and its surroundings:
// frame/button/collision inputs in, object-reset strobe and game status out.
interface game_ctrl_if;
    logic        frame_tick;
    logic        start;
    logic        hit;
    logic        miss;
    logic        obj_rst;
    logic        run;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [1:0]  state;

    modport master (
        output frame_tick, start, hit, miss,
        input  obj_rst, run, score, lives, state
    );

    modport slave (
        input  frame_tick, start, hit, miss,
        output obj_rst, run, score, lives, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencing for a ball-and-bar game: edge-detected, frame-locked
// hit/miss events drive a BCD score, a lives count and an
// IDLE/PLAY/PAUSE/OVER state machine that also strobes the object reset.
module game_ctrl #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    game_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] PAUSE_INIT = 8'(PAUSE_FRAMES);

    // Registered input copies, start arming and per-input frame locks
    logic        start_q;
    logic        hit_q;
    logic        miss_q;
    logic        start_arm_q;
    logic        hit_lock_q;
    logic        miss_lock_q;

    // Game state and registered outputs
    state_t      state_q;
    logic [15:0] score_q;
    logic [1:0]  lives_q;
    logic [7:0]  pause_q;
    logic        obj_rst_q;
    logic        run_q;

    logic        start_ev;
    logic        hit_ev;
    logic        miss_ev;
    logic        score_sat;
    logic [15:0] score_inc;
    logic [3:0]  carry;

    // start only counts once it has been seen low since reset, so a button
    // already held at reset release does not launch a game.
    assign start_ev  = bus.start & ~start_q & start_arm_q;
    assign hit_ev    = bus.hit   & ~hit_q   & ~hit_lock_q;
    assign miss_ev   = bus.miss  & ~miss_q  & ~miss_lock_q;
    assign score_sat = (score_q == 16'h9999);

    // BCD +1 as a ripple of per-digit carries; the units digit always increments.
    assign carry[0] = 1'b1;
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
        logic [3:0] digit;
        assign digit = score_q[4*gi +: 4];
        if (gi < 3) begin : g_carry
            assign carry[gi+1] = carry[gi] & (digit == 4'd9);
        end
        assign score_inc[4*gi +: 4] = !carry[gi]         ? digit :
                                      (digit == 4'd9)    ? 4'd0  :
                                                           digit + 4'd1;
    end

    // Input tracking, locks and the game state machine with its registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            start_arm_q <= 1'b0;
            hit_lock_q  <= 1'b0;
            miss_lock_q <= 1'b0;
            state_q     <= S_IDLE;
            score_q     <= 16'h0000;
            lives_q     <= 2'd0;
            pause_q     <= 8'd0;
            obj_rst_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            start_q <= bus.start;
            hit_q   <= bus.hit;
            miss_q  <= bus.miss;
            if (!bus.start) begin
                start_arm_q <= 1'b1;
            end

            // A lock set in the same cycle as a tick survives until the next tick.
            if (hit_ev) begin
                hit_lock_q <= 1'b1;
            end else if (bus.frame_tick) begin
                hit_lock_q <= 1'b0;
            end
            if (miss_ev) begin
                miss_lock_q <= 1'b1;
            end else if (bus.frame_tick) begin
                miss_lock_q <= 1'b0;
            end

            obj_rst_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ev) begin
                        state_q   <= S_PLAY;
                        run_q     <= 1'b1;
                        score_q   <= 16'h0000;
                        lives_q   <= LIVES_INIT;
                        obj_rst_q <= 1'b1;
                    end
                end
                S_PLAY: begin
                    // A miss wins over a simultaneous hit.
                    if (miss_ev) begin
                        run_q <= 1'b0;
                        if (lives_q > 2'd1) begin
                            lives_q <= lives_q - 2'd1;
                            state_q <= S_PAUSE;
                            pause_q <= PAUSE_INIT;
                        end else begin
                            lives_q <= 2'd0;
                            state_q <= S_OVER;
                        end
                    end else if (hit_ev && !score_sat) begin
                        score_q <= score_inc;
                    end
                end
                S_PAUSE: begin
                    if (bus.frame_tick) begin
                        pause_q <= pause_q - 8'd1;
                        if (pause_q == 8'd1) begin
                            state_q   <= S_PLAY;
                            run_q     <= 1'b1;
                            obj_rst_q <= 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (start_ev) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.obj_rst = obj_rst_q;
    assign bus.run     = run_q;
    assign bus.score   = score_q;
    assign bus.lives   = lives_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a fixed vector table for the opening sequence,
// hand-written corner sequences, then random stimulus against a
// decimal-score reference model.
module tb_game_ctrl;

    localparam int LIVES_P = 3;
    localparam int PF_P    = 60;

    logic clk;
    logic rst_n;
    game_ctrl_if bus ();

    game_ctrl #(.LIVES(LIVES_P), .PAUSE_FRAMES(PF_P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: game state as plain integers, score as a decimal count
    int m_state, m_lives, m_score, m_pause;
    bit m_obj, m_st_q, m_h_q, m_m_q, m_arm, m_hl, m_ml;

    typedef struct {
        bit          ft, st, h, ms;
        logic [1:0]  e_state;
        logic [1:0]  e_lives;
        logic [15:0] e_score;
        bit          e_obj;
        bit          e_run;
    } vec_t;
    vec_t vt [14];

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_score = 0; m_pause = 0; m_obj = 0;
        m_st_q = 0; m_h_q = 0; m_m_q = 0; m_arm = 0; m_hl = 0; m_ml = 0;
    endtask

    task automatic model_step(input bit ft, input bit st, input bit h, input bit ms);
        bit sev, hev, mev;
        sev = st && !m_st_q && m_arm;
        hev = h  && !m_h_q  && !m_hl;
        mev = ms && !m_m_q  && !m_ml;
        m_obj = 0;
        case (m_state)
            0: if (sev) begin m_state = 1; m_score = 0; m_lives = LIVES_P; m_obj = 1; end
            1: begin
                if (mev) begin
                    if (m_lives > 1) begin m_lives--; m_state = 2; m_pause = PF_P; end
                    else begin m_lives = 0; m_state = 3; end
                end else if (hev && m_score < 9999) begin
                    m_score++;
                end
            end
            2: if (ft) begin
                m_pause--;
                if (m_pause == 0) begin m_state = 1; m_obj = 1; end
            end
            default: if (sev) m_state = 0;
        endcase
        if (hev) m_hl = 1; else if (ft) m_hl = 0;
        if (mev) m_ml = 1; else if (ft) m_ml = 0;
        m_st_q = st; m_h_q = h; m_m_q = ms;
        if (!st) m_arm = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"},   32'(bus.state),   32'(m_state));
        chk({tag, ".lives"},   32'(bus.lives),   32'(m_lives));
        chk({tag, ".score"},   32'(bus.score),   32'(to_bcd(m_score)));
        chk({tag, ".obj_rst"}, 32'(bus.obj_rst), 32'(m_obj));
        chk({tag, ".run"},     32'(bus.run),     32'(m_state == 1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".state"},   32'(bus.state),   32'd0);
        chk({tag, ".lives"},   32'(bus.lives),   32'd0);
        chk({tag, ".score"},   32'(bus.score),   32'd0);
        chk({tag, ".obj_rst"}, 32'(bus.obj_rst), 32'd0);
        chk({tag, ".run"},     32'(bus.run),     32'd0);
    endtask

    // Drive inputs, take one rising edge, advance the model, settle 1 ns past the edge
    task automatic cycle(input bit ft, input bit st, input bit h, input bit ms);
        bus.frame_tick = ft; bus.start = st; bus.hit = h; bus.miss = ms;
        @(posedge clk);
        model_step(ft, st, h, ms);
        #1;
    endtask

    task automatic mcycle(input string tag, input bit ft, input bit st, input bit h, input bit ms);
        cycle(ft, st, h, ms);
        check_model(tag);
    endtask

    task automatic do_hit();
        mcycle("hit_tick", 1, 0, 0, 0);
        mcycle("hit_rise", 0, 0, 1, 0);
    endtask

    task automatic lose_life_and_resume();
        mcycle("miss", 0, 0, 0, 1);
        for (int k = 0; k < PF_P; k++) mcycle("pause_tick", 1, 0, 0, 0);
    endtask

    initial begin
        vt[0]  = '{0,0,0,0, 2'd0, 2'd0, 16'h0000, 0, 0};
        vt[1]  = '{0,1,0,0, 2'd1, 2'd3, 16'h0000, 1, 1};
        vt[2]  = '{0,1,0,0, 2'd1, 2'd3, 16'h0000, 0, 1};
        vt[3]  = '{0,0,1,0, 2'd1, 2'd3, 16'h0001, 0, 1};
        vt[4]  = '{0,0,1,0, 2'd1, 2'd3, 16'h0001, 0, 1};
        vt[5]  = '{0,0,1,0, 2'd1, 2'd3, 16'h0001, 0, 1};
        vt[6]  = '{0,0,1,0, 2'd1, 2'd3, 16'h0001, 0, 1};
        vt[7]  = '{0,0,1,0, 2'd1, 2'd3, 16'h0001, 0, 1};
        vt[8]  = '{1,0,0,0, 2'd1, 2'd3, 16'h0001, 0, 1};
        vt[9]  = '{0,0,1,0, 2'd1, 2'd3, 16'h0002, 0, 1};
        vt[10] = '{0,0,0,0, 2'd1, 2'd3, 16'h0002, 0, 1};
        vt[11] = '{0,0,1,0, 2'd1, 2'd3, 16'h0002, 0, 1};
        vt[12] = '{1,0,0,0, 2'd1, 2'd3, 16'h0002, 0, 1};
        vt[13] = '{0,0,0,1, 2'd2, 2'd2, 16'h0002, 0, 0};

        rst_n = 1'b0;
        bus.frame_tick = 0; bus.start = 0; bus.hit = 0; bus.miss = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Opening sequence from the vector table
        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].ft, vt[i].st, vt[i].h, vt[i].ms);
            chk($sformatf("vec%0d.state", i),   32'(bus.state),   32'(vt[i].e_state));
            chk($sformatf("vec%0d.lives", i),   32'(bus.lives),   32'(vt[i].e_lives));
            chk($sformatf("vec%0d.score", i),   32'(bus.score),   32'(vt[i].e_score));
            chk($sformatf("vec%0d.obj_rst", i), 32'(bus.obj_rst), 32'(vt[i].e_obj));
            chk($sformatf("vec%0d.run", i),     32'(bus.run),     32'(vt[i].e_run));
        end

        // Pause of 60 frames, obj_rst only on the last tick
        for (int k = 1; k <= PF_P; k++) begin
            cycle(1, 0, 0, 0);
            chk("pause.state",   32'(bus.state),   (k < PF_P) ? 32'd2 : 32'd1);
            chk("pause.obj_rst", 32'(bus.obj_rst), (k < PF_P) ? 32'd0 : 32'd1);
            mcycle("pause_gap", 0, 0, 0, 0);
        end

        // Reset in the middle of a pause, then release with start held
        mcycle("miss2", 0, 0, 0, 1);
        for (int k = 0; k < 30; k++) mcycle("pause30", 1, 0, 0, 0);
        chk("pause30.state", 32'(bus.state), 32'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        bus.start = 1'b1;
        model_reset();
        @(posedge clk);
        #1 check_reset_values("held_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) mcycle("start_held", 0, 1, 0, 0);
        chk("start_held.state", 32'(bus.state), 32'd0);
        mcycle("start_low", 0, 0, 0, 0);
        mcycle("start_rise", 0, 1, 0, 0);
        chk("restart.state",   32'(bus.state),   32'd1);
        chk("restart.obj_rst", 32'(bus.obj_rst), 32'd1);
        mcycle("after_restart", 0, 1, 0, 0);
        chk("restart.obj_once", 32'(bus.obj_rst), 32'd0);

        // BCD carry across two digits, then saturation at 9999
        for (int k = 0; k < 99; k++) do_hit();
        chk("score_0099", 32'(bus.score), 32'h0099);
        do_hit();
        chk("score_0100", 32'(bus.score), 32'h0100);
        for (int k = 100; k < 9999; k++) do_hit();
        chk("score_9999", 32'(bus.score), 32'h9999);
        do_hit();
        chk("score_sat", 32'(bus.score), 32'h9999);

        // Down to one life, then simultaneous hit and miss ends the game
        lose_life_and_resume();
        lose_life_and_resume();
        chk("one_life.lives", 32'(bus.lives), 32'd1);
        mcycle("hit_miss", 0, 0, 1, 1);
        chk("over.state", 32'(bus.state), 32'd3);
        chk("over.lives", 32'(bus.lives), 32'd0);
        chk("over.score", 32'(bus.score), 32'h9999);
        mcycle("over_start", 0, 1, 0, 0);
        chk("idle.state", 32'(bus.state), 32'd0);
        chk("idle.score", 32'(bus.score), 32'h9999);
        mcycle("idle_rel", 0, 0, 0, 0);

        // Random stimulus against the model
        for (int k = 0; k < 6000; k++) begin
            mcycle("rand",
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 15) == 0,
                   $urandom_range(0, 2) == 0,
                   $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
